// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CNT_LO,
      S_CNT_HI,
      S_DATA,
      S_WRITE,
      S_DONE,
      S_ERR
   } state_t;

   localparam int BYTES_PER_WORD = 4;
   localparam int COUNT_W        = 16;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian 4-byte assembly register: the first byte shifted in ends up in bits [7:0].
module byte_packer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_clear,
   input  logic        i_shift,
   input  logic [7:0]  i_byte,
   output logic [31:0] o_word,
   output logic [1:0]  o_idx,
   output logic        o_word_ready
);

   logic [31:0] r_word;
   logic [1:0]  r_idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_word <= '0;
         r_idx  <= '0;
      end else if (i_clear) begin
         r_idx <= '0;
      end else if (i_shift) begin
         r_word <= {i_byte, r_word[31:8]};
         r_idx  <= r_idx + 2'd1;
      end
   end

   // Asserted on the cycle the 4th byte is being accepted, so the FSM can move to WRITE on that edge.
   assign o_word_ready = i_shift && (r_idx == 2'd3) && !i_clear;
   assign o_word       = r_word;
   assign o_idx        = r_idx;

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory programmer: count-prefixed byte stream in, one 32-bit write per word out.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int MEM_DEPTH = 32,
   parameter int SIZE      = 32,
   localparam int CW       = $clog2(MEM_DEPTH) + 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [7:0]      in_data,
   input  logic            in_valid,
   output logic            in_ready,
   output logic            WE,
   output logic [31:0]     WA,
   output logic [SIZE-1:0] WD,
   output logic            cpu_hold,
   output logic            done,
   output logic            err,
   output logic [CW-1:0]   words_loaded
);

   state_t               r_state;
   state_t               w_next;
   logic                 w_arm;
   logic                 w_accept;
   logic                 w_shift;
   logic                 w_clear;
   logic                 w_word_ready;
   logic [31:0]          w_word;
   logic [1:0]           w_idx;
   logic [COUNT_W-1:0]   w_n;
   logic [CW-1:0]        w_words_inc;

   logic [COUNT_W-1:0]   r_count;
   logic [CW-1:0]        r_words;
   logic                 r_in_ready;
   logic                 r_we;
   logic                 r_cpu_hold;
   logic                 r_done;
   logic                 r_err;

   assign w_accept    = in_valid && r_in_ready;
   assign w_shift     = w_accept && (r_state == S_DATA);
   assign w_clear     = (r_state == S_IDLE) || w_arm;
   assign w_n         = {in_data, r_count[7:0]};
   assign w_words_inc = r_words + 1'b1;

   byte_packer u_packer (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_clear      (w_clear),
      .i_shift      (w_shift),
      .i_byte       (in_data),
      .o_word       (w_word),
      .o_idx        (w_idx),
      .o_word_ready (w_word_ready)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      w_arm  = 1'b0;
      unique case (r_state)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               w_next = S_CNT_LO;
               w_arm  = 1'b1;
            end
         end
         S_CNT_LO: if (w_accept) w_next = S_CNT_HI;
         S_CNT_HI: begin
            if (w_accept) begin
               if (w_n == '0)                         w_next = S_DONE;
               else if (w_n > COUNT_W'(MEM_DEPTH))    w_next = S_ERR;
               else                                   w_next = S_DATA;
            end
         end
         S_DATA:  if (w_word_ready) w_next = S_WRITE;
         S_WRITE: w_next = (COUNT_W'(w_words_inc) == r_count) ? S_DONE : S_DATA;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
         r_words <= '0;
      end else begin
         if (w_accept && r_state == S_CNT_LO) r_count[7:0]  <= in_data;
         if (w_accept && r_state == S_CNT_HI) r_count[15:8] <= in_data;
         if (w_clear)                     r_words <= '0;
         else if (r_state == S_WRITE)     r_words <= w_words_inc;
      end
   end

   // Status/handshake outputs are decoded from the next state so each is a plain flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_in_ready <= 1'b0;
         r_we       <= 1'b0;
         r_cpu_hold <= 1'b1;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_in_ready <= (w_next == S_CNT_LO) || (w_next == S_CNT_HI) || (w_next == S_DATA);
         r_we       <= (w_next == S_WRITE);
         r_cpu_hold <= (w_next != S_DONE);
         r_done     <= (w_next == S_DONE);
         r_err      <= (w_next == S_ERR);
      end
   end

   assign in_ready     = r_in_ready;
   assign WE           = r_we;
   assign WA           = 32'({r_words, 2'b00});
   assign WD           = SIZE'(w_word);
   assign cpu_hold     = r_cpu_hold;
   assign done         = r_done;
   assign err          = r_err;
   assign words_loaded = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus queues expected writes, a negedge monitor checks each WE.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        WE;
   logic [31:0] WA;
   logic [31:0] WD;
   logic        cpu_hold;
   logic        done;
   logic        err;
   logic [5:0]  words_loaded;

   int          vectors = 0;
   int          miscompares = 0;
   logic [63:0] exp_q[$];
   logic [31:0] words[0:31];

   imem_loader #(.MEM_DEPTH(32), .SIZE(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .WE           (WE),
      .WA           (WA),
      .WD           (WD),
      .cpu_hold     (cpu_hold),
      .done         (done),
      .err          (err),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin : monitor
      logic [63:0] e;
      if (rst_n && WE) begin
         check("in_ready_during_write", 32'(in_ready), 32'd0);
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_write: got WA=0x%0h WD=0x%0h, expected no write", WA, WD);
         end else begin
            e = exp_q.pop_front();
            check("write_addr", WA, e[63:32]);
            check("write_data", WD, e[31:0]);
         end
      end
   end

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit bp);
      int budget;
      if (bp) begin
         repeat ($urandom_range(0, 3)) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
         end
      end
      in_data  = b;
      in_valid = 1'b1;
      budget   = 0;
      while (!in_ready && budget < 50) begin
         @(posedge clk); #1;
         budget++;
      end
      if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input bit bp);
      send_byte(w[7:0], bp);
      send_byte(w[15:8], bp);
      send_byte(w[23:16], bp);
      send_byte(w[31:24], bp);
   endtask

   task automatic load(input logic [15:0] n, input int nw, input bit bp);
      pulse_start();
      send_byte(n[7:0], bp);
      send_byte(n[15:8], bp);
      for (int i = 0; i < nw; i++) begin
         exp_q.push_back({32'(i * 4), words[i]});
         send_word(words[i], bp);
      end
   endtask

   task automatic wait_done();
      for (int i = 0; i < 20 && !done; i++) begin
         @(posedge clk); #1;
      end
      check("done_level", 32'(done), 32'd1);
   endtask

   initial begin
      // Reset with a byte offered: nothing may be accepted
      rst_n    = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'hAA;
      #12;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
      check("rst_we", 32'(WE), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_words", 32'(words_loaded), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("idle_in_ready", 32'(in_ready), 32'd0);
      in_valid = 1'b0;

      // Two-word load, full throughput
      words[0] = 32'h20080020;
      words[1] = 32'h21090005;
      load(16'd2, 2, 1'b0);
      wait_done();
      check("two_cpu_hold", 32'(cpu_hold), 32'd0);
      check("two_words", 32'(words_loaded), 32'd2);
      check("two_q_empty", 32'(exp_q.size()), 32'd0);

      // Same frame under random backpressure
      load(16'd2, 2, 1'b1);
      wait_done();
      check("bp_words", 32'(words_loaded), 32'd2);
      check("bp_q_empty", 32'(exp_q.size()), 32'd0);

      // N = 0: cpu_hold rises on start, done returns right after the count
      pulse_start();
      check("n0_hold_rise", 32'(cpu_hold), 32'd1);
      check("n0_done_clr", 32'(done), 32'd0);
      check("n0_words_clr", 32'(words_loaded), 32'd0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      check("n0_done", 32'(done), 32'd1);
      check("n0_cpu_hold", 32'(cpu_hold), 32'd0);
      check("n0_words", 32'(words_loaded), 32'd0);

      // N = MEM_DEPTH: last write lands at 0x7C
      for (int i = 0; i < 32; i++)
         words[i] = {8'(i), 8'hA5, 8'(i * 3), 8'h5A};
      load(16'd32, 32, 1'b0);
      wait_done();
      check("n32_words", 32'(words_loaded), 32'd32);
      check("n32_q_empty", 32'(exp_q.size()), 32'd0);

      // N = MEM_DEPTH + 1: error, no bytes accepted, no writes
      pulse_start();
      send_byte(8'h21, 1'b0);
      send_byte(8'h00, 1'b0);
      check("n33_err", 32'(err), 32'd1);
      check("n33_in_ready", 32'(in_ready), 32'd0);
      check("n33_cpu_hold", 32'(cpu_hold), 32'd1);
      check("n33_done", 32'(done), 32'd0);
      in_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("n33_still_err", 32'(err), 32'd1);
      check("n33_still_blocked", 32'(in_ready), 32'd0);

      // Mid-load abort after 2 bytes of the second word
      words[0] = 32'h20080020;
      words[1] = 32'h21090005;
      pulse_start();
      check("restart_err_clr", 32'(err), 32'd0);
      send_byte(8'h02, 1'b0);
      send_byte(8'h00, 1'b0);
      exp_q.push_back({32'h0, words[0]});
      send_word(words[0], 1'b0);
      send_byte(words[1][7:0], 1'b0);
      send_byte(words[1][15:8], 1'b0);
      rst_n = 1'b0;
      #1;
      check("abort_q_empty", 32'(exp_q.size()), 32'd0);
      check("abort_words", 32'(words_loaded), 32'd0);
      check("abort_we", 32'(WE), 32'd0);
      check("abort_cpu_hold", 32'(cpu_hold), 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      load(16'd2, 2, 1'b0);
      wait_done();
      check("abort_reload_words", 32'(words_loaded), 32'd2);

      // start pulsed during DATA is ignored
      pulse_start();
      send_byte(8'h02, 1'b0);
      send_byte(8'h00, 1'b0);
      exp_q.push_back({32'h0, words[0]});
      exp_q.push_back({32'h4, words[1]});
      send_word(words[0], 1'b0);
      send_byte(words[1][7:0], 1'b0);
      send_byte(words[1][15:8], 1'b0);
      pulse_start();
      send_byte(words[1][23:16], 1'b0);
      send_byte(words[1][31:24], 1'b0);
      wait_done();
      check("ign_words", 32'(words_loaded), 32'd2);
      check("ign_cpu_hold", 32'(cpu_hold), 32'd0);

      repeat (3) @(posedge clk);
      #1;
      check("final_q_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
